imm_encoder: RTL and testbench

Immediate packer, the inverse of the core's immediate extender. It takes a 32-bit immediate, a format code and a base instruction word, and scatters the immediate bits into the RISC-V field positions for that format. It also checks that the immediate is representable in that format. Two-stage valid/ready pipeline, one result per cycle; used by the instruction-memory loader/patcher for branch and jump relocation and for self-test program generation.

---
 rtl/imm_encoder.sv | 132 +++++++++++++
 tb/tb_imm_encoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// rtl/imm_encoder.sv - RISC-V immediate packer with range check, 2-stage valid/ready pipeline
// Define IMM_ENC_RANGE_CHECK_EN to flag immediates not representable in the selected format.
module imm_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [31:0]      in_base,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  logic        s1_valid;
  logic [2:0]  s1_fmt;
  logic [31:0] s1_base;
  logic [31:0] s1_imm;
  logic        s1_rng_err;
  logic        s1_adv;
  logic        s2_adv;
  logic        rng_err;
  logic        illegal;
  logic [31:0] mask;
  logic [31:0] packed_imm;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

`ifdef IMM_ENC_RANGE_CHECK_EN
  // Signed formats: every bit above the top encoded bit must match the sign bit.
  always_comb begin
    rng_err = 1'b0;
    case (in_fmt)
      3'd0:       rng_err = |in_imm[31:5];
      3'd1, 3'd2: rng_err = !(&in_imm[31:11] || ~|in_imm[31:11]);
      3'd3:       rng_err = !(&in_imm[31:12] || ~|in_imm[31:12]) || in_imm[0];
      3'd4:       rng_err = |in_imm[11:0];
      3'd5:       rng_err = !(&in_imm[31:20] || ~|in_imm[31:20]) || in_imm[0];
      default:    rng_err = 1'b0;
    endcase
  end
`else
  assign rng_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_fmt     <= 3'd0;
      s1_base    <= 32'd0;
      s1_imm     <= 32'd0;
      s1_rng_err <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_fmt     <= in_fmt;
        s1_base    <= in_base;
        s1_imm     <= in_imm;
        s1_rng_err <= rng_err;
      end
    end
  end

  always_comb begin
    mask       = 32'h0000_0000;
    packed_imm = 32'h0000_0000;
    illegal    = 1'b0;
    case (s1_fmt)
      3'd0: begin
        mask       = 32'h01F0_0000;
        packed_imm = {7'd0, s1_imm[4:0], 20'd0};
      end
      3'd1: begin
        mask       = 32'hFFF0_0000;
        packed_imm = {s1_imm[11:0], 20'd0};
      end
      3'd2: begin
        mask       = 32'hFE00_0F80;
        packed_imm = {s1_imm[11:5], 13'd0, s1_imm[4:0], 7'd0};
      end
      3'd3: begin
        mask       = 32'hFE00_0F80;
        packed_imm = {s1_imm[12], s1_imm[10:5], 13'd0, s1_imm[4:1], s1_imm[11], 7'd0};
      end
      3'd4: begin
        mask       = 32'hFFFF_F000;
        packed_imm = {s1_imm[31:12], 12'd0};
      end
      3'd5: begin
        mask       = 32'hFFFF_F000;
        packed_imm = {s1_imm[20], s1_imm[10:1], s1_imm[11], s1_imm[19:12], 12'd0};
      end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= 32'd0;
      out_err   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= (s1_base & ~mask) | packed_imm;
        out_err   <= s1_rng_err || illegal;
      end
    end
  end

  // Statistics count delivered results only, wrapping silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_cnt <= '0;
      err_cnt <= '0;
    end else if (out_valid && out_ready) begin
      enc_cnt <= enc_cnt + 1'b1;
      if (out_err) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// tb/tb_imm_encoder.sv - self-checking bench for imm_encoder with a bit-map reference model
module tb_imm_encoder;

  localparam int CNT_W = 16;
`ifdef IMM_ENC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_fmt = 3'd0;
  logic [31:0]      in_base = 32'd0;
  logic [31:0]      in_imm = 32'd0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic             out_err;
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] err_cnt;

  int   errors = 0;
  int   checks = 0;
  exp_t q[$];
  logic [CNT_W-1:0] m_enc = '0;
  logic [CNT_W-1:0] m_err = '0;
  bit   rand_rdy = 1'b0;

  imm_encoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_base(in_base), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .enc_cnt(enc_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Which immediate bit lands in instruction bit i (-1 = base bit kept).
  function automatic int src_bit(input int f, input int i);
    case (f)
      0: return (i >= 20 && i <= 24) ? i - 20 : -1;
      1: return (i >= 20) ? i - 20 : -1;
      2: begin
        if (i >= 25) return i - 20;
        else if (i >= 7 && i <= 11) return i - 7;
        else return -1;
      end
      3: begin
        if (i == 31) return 12;
        else if (i >= 25) return i - 20;
        else if (i == 7) return 11;
        else if (i >= 8 && i <= 11) return i - 7;
        else return -1;
      end
      4: return (i >= 12) ? i : -1;
      5: begin
        if (i == 31) return 20;
        else if (i >= 21) return i - 20;
        else if (i == 20) return 11;
        else if (i >= 12) return i;
        else return -1;
      end
      default: return -1;
    endcase
  endfunction

  function automatic bit representable(input int f, input logic [31:0] imm);
    longint s;
    s = longint'($signed(imm));
    case (f)
      0:    return imm < 32;
      1, 2: return s >= -2048 && s <= 2047;
      3:    return s >= -4096 && s <= 4095 && (imm % 2) == 0;
      4:    return (imm % 4096) == 0;
      5:    return s >= -1048576 && s <= 1048575 && (imm % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic exp_t model(input int f, input logic [31:0] base, input logic [31:0] imm);
    exp_t e;
    int   sb;
    e.instr = base;
    if (f <= 5) begin
      for (int i = 0; i < 32; i++) begin
        sb = src_bit(f, i);
        if (sb >= 0) e.instr[i] = imm[sb];
      end
      e.err = RC && !representable(f, imm);
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: check deliveries against queued expectations, then record new accepts.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      m_enc = '0;
      m_err = '0;
    end else begin
      chk("enc_cnt", 32'(enc_cnt), 32'(m_enc));
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
      if (out_valid && out_ready) begin
        checks++;
        assert (q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_output: observed instr %h expected no result", out_instr);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("out_instr", out_instr, e.instr);
          chk("out_err", 32'(out_err), 32'(e.err));
          m_enc = m_enc + 1'b1;
          if (e.err) m_err = m_err + 1'b1;
        end
      end
      if (in_valid && in_ready) q.push_back(model(int'(in_fmt), in_base, in_imm));
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] f, input logic [31:0] b, input logic [31:0] i);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_fmt   = f;
    in_base  = b;
    in_imm   = i;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL send_timeout: observed in_ready low for 200 cycles expected accept");
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 2000 && !ok; t++) begin
      @(negedge clk);
      if (q.size() == 0) ok = 1'b1;
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL drain_timeout: observed %0d pending expected 0", q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic run1(input string tag, input logic [2:0] f, input logic [31:0] b,
                      input logic [31:0] i, input logic [31:0] ei, input logic ee);
    send(f, b, i);
    @(negedge clk);
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat2"}, 32'(out_valid), 32'd1);
    chk({tag, "_instr"}, out_instr, ei);
    chk({tag, "_err"}, 32'(out_err), 32'(ee));
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t        ea;
    logic [2:0]  f;
    logic [31:0] b;
    logic [31:0] imm;

    do_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    out_ready = 1'b1;
    run1("i_neg1",   3'd1, 32'h0000_0093, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0);
    run1("b_max",    3'd3, 32'h0000_0063, 32'h0000_0800, 32'h0000_00E3, 1'b0);
    run1("b_odd",    3'd3, 32'h0000_0063, 32'h0000_0801, 32'h0000_00E3, RC);
    run1("j_neg4",   3'd5, 32'h0000_006F, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
    run1("j_ovf",    3'd5, 32'h0000_006F, 32'h0010_0000, 32'h8000_006F, RC);
    run1("u_lui",    3'd4, 32'h0000_0037, 32'h1234_5000, 32'h1234_5037, 1'b0);
    run1("sh_31",    3'd0, 32'h4000_5013, 32'h0000_001F, 32'h41F0_5013, 1'b0);
    run1("sh_32",    3'd0, 32'h4000_5013, 32'h0000_0020, 32'h4000_5013, RC);
    run1("illegal6", 3'd6, 32'hDEAD_BEEF, 32'h0000_0123, 32'hDEAD_BEEF, 1'b1);
    chk("dir_enc_cnt", 32'(enc_cnt), 32'd9);
    chk("dir_err_cnt", 32'(err_cnt), 32'd1 + 32'(RC) * 32'd3);

    // Stall: two requests fill both stages, a third must wait.
    do_reset();
    out_ready = 1'b0;
    ea = model(2, 32'h0000_2023, 32'hFFFF_F800);
    send(3'd2, 32'h0000_2023, 32'hFFFF_F800);
    send(3'd1, 32'h0000_0013, 32'h0000_07FF);
    in_valid = 1'b1;
    in_fmt   = 3'd4;
    in_base  = 32'h0000_0017;
    in_imm   = 32'hABCD_E000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_instr", out_instr, ea.instr);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd4, 32'h0000_0017, 32'hABCD_E000);
    drain();
    chk("stall_enc_cnt", 32'(enc_cnt), 32'd3);

    // Random traffic with random back-pressure.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      f = 3'($urandom_range(0, 7));
      b = $urandom;
      case ($urandom_range(0, 3))
        0: imm = $urandom;
        1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: imm = 32'($urandom_range(0, 32'h3F_FFFF)) - 32'h20_0000;
        default: imm = $urandom & 32'hFFFF_F000;
      endcase
      send(f, b, imm);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    // Reset with both stages full discards everything in flight.
    out_ready = 1'b0;
    send(3'd1, 32'h0000_0013, 32'h0000_0005);
    send(3'd5, 32'h0000_006F, 32'h0000_0100);
    do_reset();
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_enc_cnt", 32'(enc_cnt), 32'd0);
    chk("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_stale_out", 32'(out_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
